// File: rtl/rysy_arb_pkg.sv
// rysy_arb_pkg: shared types and defaults for the rysy memory arbiter.
//   arb_state_t   : arbitration state (ARB = open, LOCK1 = loader holds bus)
//   M_CORE/M_LOAD : master ids used for the read-return owner
//   ARB_*         : default widths and hold limit
package rysy_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam int unsigned M_CORE = 0;
    localparam int unsigned M_LOAD = 1;

    localparam int unsigned ARB_ADDR_W   = 32;
    localparam int unsigned ARB_DATA_W   = 32;
    localparam int unsigned ARB_MAX_HOLD = 4;
    localparam int unsigned STARVE_W     = 4;

endpackage

// File: rtl/rysy_arb_rsp.sv
// rysy_arb_rsp: read-return tracker for the arbiter.
// Remembers which master issued the read granted last cycle and steers the
// memory's read data back to that master for exactly one cycle.
//   clk, rst          : clock, synchronous active-high reset
//   issue             : a read was granted this cycle
//   issue_owner       : id of the master that owns that read (M_CORE/M_LOAD)
//   mem_rdata         : memory read data (valid one cycle after the address)
//   m0_rvalid/rdata   : core read return
//   m1_rvalid/rdata   : loader read return
module rysy_arb_rsp
    import rysy_arb_pkg::*;
#(
    parameter int unsigned DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata
);

    logic valid_q;
    logic owner_q;

    // One-deep return pipeline matching the memory's read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            owner_q <= 1'(M_CORE);
        end else begin
            valid_q <= issue;
            owner_q <= issue_owner;
        end
    end

    // Route data to the owner; a reset cycle suppresses any pending return.
    always_comb begin
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (valid_q && !rst) begin
            if (owner_q == 1'(M_LOAD)) begin
                m1_rvalid = 1'b1;
                m1_rdata  = mem_rdata;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/rysy_mem_arbiter.sv
// rysy_mem_arbiter: shares one synchronous single-port RAM between the
// rysy_core port (m0) and a loader/debug port (m1).
// Fixed priority to the core, a starvation guard that forces a loader grant
// after MAX_HOLD consecutive core grants while the loader waits, and a loader
// lock (m1_lock) that keeps the bus for atomic bursts.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   m0_* / m1_*                  : req/addr/wdata/we/be in, gnt/rvalid/rdata out
//   m1_lock                      : loader bus lock, meaningful with m1_req
//   mem_addr/wdata/we/be         : memory request (combinational from grant)
//   mem_rdata                    : memory read data, one cycle after address
// Optional build macro RYSY_ARB_PERF_EN adds perf_m0_grants, perf_m1_grants
// and perf_m1_wait (32-bit wrapping counters).
module rysy_mem_arbiter
    import rysy_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ARB_ADDR_W,
    parameter int unsigned DATA_W   = ARB_DATA_W,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic                  m0_we,
    input  logic [DATA_W/8-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    input  logic                  m1_req,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic                  m1_we,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef RYSY_ARB_PERF_EN
    ,
    output logic [31:0]           perf_m0_grants,
    output logic [31:0]           perf_m1_grants,
    output logic [31:0]           perf_m1_wait
`endif
);

    localparam logic [STARVE_W-1:0] HOLD_LIMIT = STARVE_W'(MAX_HOLD);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;
    logic                gnt0;
    logic                gnt1;

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Grant decision, next state and starvation counter update.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_next  = state;
        starve_next = starve_cnt;
        if (!rst) begin
            unique case (state)
                ARB: begin
                    if (m0_req && !((starve_cnt == HOLD_LIMIT) && m1_req)) begin
                        gnt0 = 1'b1;
                    end else if (m1_req) begin
                        gnt1 = 1'b1;
                    end
                    // Only a granted loader beat can take the lock.
                    if (gnt1 && m1_lock) begin
                        state_next = LOCK1;
                    end
                end
                LOCK1: begin
                    gnt1 = m1_req;
                    if ((gnt1 && !m1_lock) || (!m1_req && !m1_lock)) begin
                        state_next = ARB;
                    end
                end
                default: state_next = ARB;
            endcase

            // Counts core wins the loader had to sit through; saturates.
            if (gnt1 || !m1_req) begin
                starve_next = '0;
            end else if (gnt0 && (starve_cnt < HOLD_LIMIT)) begin
                starve_next = starve_cnt + STARVE_W'(1);
            end
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Memory request mux; idle bus is driven to all zeros.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        if (gnt0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
            mem_be    = m0_be;
        end else if (gnt1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
            mem_be    = m1_be;
        end
    end

    rysy_arb_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp (
        .clk         (clk),
        .rst         (rst),
        .issue       ((gnt0 && !m0_we) || (gnt1 && !m1_we)),
        .issue_owner (gnt1),
        .mem_rdata   (mem_rdata),
        .m0_rvalid   (m0_rvalid),
        .m0_rdata    (m0_rdata),
        .m1_rvalid   (m1_rvalid),
        .m1_rdata    (m1_rdata)
    );

`ifdef RYSY_ARB_PERF_EN
    // Transfer and loader-wait counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_m0_grants <= '0;
            perf_m1_grants <= '0;
            perf_m1_wait   <= '0;
        end else begin
            if (m0_req && gnt0) begin
                perf_m0_grants <= perf_m0_grants + 32'd1;
            end
            if (m1_req && gnt1) begin
                perf_m1_grants <= perf_m1_grants + 32'd1;
            end
            if (m1_req && !gnt1) begin
                perf_m1_wait <= perf_m1_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rysy_mem_arbiter.sv
// Self-checking bench for rysy_mem_arbiter: directed scenarios plus a
// randomized run, all checked against a behavioural model of the arbiter.
module tb_rysy_mem_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_HOLD = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_be;
`ifdef RYSY_ARB_PERF_EN
    logic [31:0] perf_m0_grants, perf_m1_grants, perf_m1_wait;
`endif

    rysy_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_we     (m0_we),
        .m0_be     (m0_be),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_we     (m1_we),
        .m1_be     (m1_be),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
`ifdef RYSY_ARB_PERF_EN
        ,
        .perf_m0_grants (perf_m0_grants),
        .perf_m1_grants (perf_m1_grants),
        .perf_m1_wait   (perf_m1_wait)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Simple synchronous RAM (64 words) standing in for the shared memory.
    logic [31:0] ram [64];
    logic        ram_load;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h00500113 : (32'hC0DE0000 | 32'(i * 7));
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else begin
            mem_rdata <= ram[mem_addr[7:2]];
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // Behavioural model: who should win, what the memory holds, what returns.
    logic [31:0] shadow [64];
    bit          md_locked;
    int          md_starve;
    bit          md_pv;
    bit          md_pown;
    logic [31:0] md_pdata;
    bit          exp_g0, exp_g1;
    int unsigned md_p0, md_p1, md_pw;

    function automatic void shadow_write(input logic [5:0] idx, input logic [31:0] d,
                                         input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void model_predict();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (rst) return;
        if (md_locked) exp_g1 = m1_req;
        else if (m0_req && !(md_starve == int'(MAX_HOLD) && m1_req)) exp_g0 = 1'b1;
        else exp_g1 = m1_req;
    endfunction

    function automatic void model_advance();
        model_predict();
        if (rst) begin
            md_locked = 1'b0; md_starve = 0; md_pv = 1'b0;
            md_p0 = 0; md_p1 = 0; md_pw = 0;
            return;
        end
        md_pv   = (exp_g0 && !m0_we) || (exp_g1 && !m1_we);
        md_pown = exp_g1;
        if (exp_g0) begin
            if (!m0_we) md_pdata = shadow[m0_addr[7:2]];
            else shadow_write(m0_addr[7:2], m0_wdata, m0_be);
            md_p0++;
        end
        if (exp_g1) begin
            if (!m1_we) md_pdata = shadow[m1_addr[7:2]];
            else shadow_write(m1_addr[7:2], m1_wdata, m1_be);
            md_p1++;
        end
        if (m1_req && !exp_g1) md_pw++;
        if (exp_g1 || !m1_req) md_starve = 0;
        else if (exp_g0 && md_starve < int'(MAX_HOLD)) md_starve++;
        if (!md_locked) md_locked = exp_g1 && m1_lock;
        else if ((exp_g1 && !m1_lock) || (!m1_req && !m1_lock)) md_locked = 1'b0;
    endfunction

    task automatic settle();
        #2;
        model_predict();
    endtask

    task automatic cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0; m1_lock = 0;
    endtask

    task automatic test_reset();
        rst = 1; m0_req = 1; m0_be = 4'hF;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs c%0d got %b need 00000", c,
                         {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we});
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
                errors++;
                $display("FAIL reset_mem_bus c%0d addr %h be %h", c, mem_addr, mem_be);
            end
            cycle();
        end
        rst = 0;
        settle();
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant got %b need 1", m0_gnt);
        end
        cycle();
        m0_req = 0;
    endtask

    task automatic test_core_read();
        drive_idle();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_be = 4'hF;
        settle();
        checks++;
        if (m0_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL core_read_issue gnt %b addr %h we %b need 1 00000010 0",
                     m0_gnt, mem_addr, mem_we);
        end
        cycle();
        m0_req = 0;
        settle();
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h00500113 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_return rv0 %b rdata %h rv1 %b need 1 00500113 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        cycle();
    endtask

    task automatic test_contention();
        drive_idle();
        settle();
        cycle();
        m0_req = 1; m0_addr = 32'h14; m0_be = 4'hF;
        m1_req = 1; m1_addr = 32'h20; m1_be = 4'hF;
        for (int k = 0; k < 15; k++) begin
            bit want1;
            want1 = (k % 5) == 4;
            settle();
            checks++;
            if (m0_gnt !== !want1 || m1_gnt !== want1) begin
                errors++;
                $display("FAIL contention k%0d gnt0 %b gnt1 %b need %b %b",
                         k, m0_gnt, m1_gnt, !want1, want1);
            end
            cycle();
        end
        drive_idle();
        settle();
        cycle();
    endtask

    task automatic test_lock_burst();
        int n;
        logic [31:0] wd;
        drive_idle();
        settle();
        cycle();
        m0_req = 1; m0_addr = 32'h30; m0_be = 4'hF;
        wd = $urandom;
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h0; m1_wdata = wd; m1_be = 4'hF;
        n = 0;
        settle();
        while (m1_gnt !== 1'b1 && n < 10) begin
            cycle();
            settle();
            n++;
        end
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== wd) begin
            errors++;
            $display("FAIL lock_beat0 gnt1 %b gnt0 %b addr %h wdata %h", m1_gnt, m0_gnt,
                     mem_addr, mem_wdata);
        end
        cycle();
        for (int b = 1; b < 3; b++) begin
            m1_addr = 32'(4 * b); m1_wdata = $urandom; m1_lock = (b < 2);
            settle();
            checks++;
            if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_addr !== 32'(4 * b) || mem_we !== 1'b1) begin
                errors++;
                $display("FAIL lock_beat%0d gnt1 %b gnt0 %b addr %h we %b", b, m1_gnt, m0_gnt,
                         mem_addr, mem_we);
            end
            cycle();
        end
        m1_req = 0; m1_we = 0; m1_lock = 0;
        settle();
        checks++;
        if (m0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL lock_release gnt0 %b need 1", m0_gnt);
        end
        cycle();
        drive_idle();
        settle();
        cycle();
    endtask

    task automatic test_reset_in_lock();
        drive_idle();
        settle();
        cycle();
        m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 32'h40; m1_be = 4'hF;
        settle();
        checks++;
        if (m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rlock_enter gnt1 %b need 1", m1_gnt);
        end
        cycle();
        m0_req = 1; m0_addr = 32'h18; m0_be = 4'hF; m1_addr = 32'h44;
        settle();
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rlock_held gnt0 %b gnt1 %b need 0 1", m0_gnt, m1_gnt);
        end
        cycle();
        rst = 1;
        settle();
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, m1_rvalid} !== 4'b0) begin
            errors++;
            $display("FAIL rlock_in_reset got %b need 0000", {m0_gnt, m1_gnt, mem_we, m1_rvalid});
        end
        cycle();
        rst = 0;
        settle();
        checks++;
        if (m1_rvalid !== 1'b0 || m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rlock_after_reset rv1 %b gnt0 %b gnt1 %b need 0 1 0",
                     m1_rvalid, m0_gnt, m1_gnt);
        end
        cycle();
        drive_idle();
        settle();
        cycle();
    endtask

    task automatic test_random();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            // A pending request keeps its payload until it is granted.
            if (!m0_req || exp_g0) begin
                m0_req = ($urandom_range(0, 3) != 0);
                m0_we = $urandom_range(0, 1) == 1; m0_addr = {24'h0, 6'($urandom), 2'b00};
                m0_wdata = $urandom; m0_be = 4'($urandom);
            end
            if (!m1_req || exp_g1) begin
                m1_req = ($urandom_range(0, 2) != 0);
                m1_we = $urandom_range(0, 1) == 1; m1_addr = {24'h0, 6'($urandom), 2'b00};
                m1_wdata = $urandom; m1_be = 4'($urandom);
                m1_lock = m1_req && ($urandom_range(0, 1) == 1);
            end
            settle();
            e_addr = 0; e_wdata = 0; e_be = 0; e_we = 0;
            if (exp_g0) begin e_addr = m0_addr; e_wdata = m0_wdata; e_be = m0_be; e_we = m0_we; end
            else if (exp_g1) begin e_addr = m1_addr; e_wdata = m1_wdata; e_be = m1_be; e_we = m1_we; end
            checks++;
            if (m0_gnt !== exp_g0 || m1_gnt !== exp_g1) begin
                errors++;
                $display("FAIL rand_grant c%0d got %b%b need %b%b", c, m0_gnt, m1_gnt, exp_g0, exp_g1);
            end
            checks++;
            if ({mem_addr, mem_wdata, mem_be, mem_we} !== {e_addr, e_wdata, e_be, e_we}) begin
                errors++;
                $display("FAIL rand_mem_bus c%0d addr %h/%h wdata %h/%h be %h/%h we %b/%b", c,
                         mem_addr, e_addr, mem_wdata, e_wdata, mem_be, e_be, mem_we, e_we);
            end
            checks++;
            if (m0_rvalid !== (md_pv && !md_pown && !rst) ||
                m1_rvalid !== (md_pv && md_pown && !rst) ||
                m0_rdata !== ((md_pv && !md_pown && !rst) ? md_pdata : 32'h0) ||
                m1_rdata !== ((md_pv && md_pown && !rst) ? md_pdata : 32'h0)) begin
                errors++;
                $display("FAIL rand_return c%0d rv %b%b rdata %h %h need pv %b own %b data %h",
                         c, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, md_pv, md_pown, md_pdata);
            end
            cycle();
        end
        rst = 0;
        drive_idle();
        settle();
`ifdef RYSY_ARB_PERF_EN
        checks++;
        if (perf_m0_grants !== md_p0 || perf_m1_grants !== md_p1 || perf_m1_wait !== md_pw) begin
            errors++;
            $display("FAIL rand_perf got %0d/%0d/%0d need %0d/%0d/%0d", perf_m0_grants,
                     perf_m1_grants, perf_m1_wait, md_p0, md_p1, md_pw);
        end
`endif
        cycle();
    endtask

`ifdef RYSY_ARB_PERF_EN
    task automatic test_perf();
        drive_idle();
        rst = 1;
        settle();
        cycle();
        rst = 0;
        // Three contended cycles: core wins each, loader waits each.
        m0_req = 1; m0_addr = 32'h8; m0_be = 4'hF;
        m1_req = 1; m1_addr = 32'hC; m1_be = 4'hF;
        for (int c = 0; c < 3; c++) begin settle(); cycle(); end
        m0_req = 0;
        for (int c = 0; c < 2; c++) begin settle(); cycle(); end
        drive_idle();
        settle();
        checks++;
        if (perf_m0_grants !== 32'd3 || perf_m1_grants !== 32'd2 || perf_m1_wait !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts got %0d/%0d/%0d need 3/2/3", perf_m0_grants,
                     perf_m1_grants, perf_m1_wait);
        end
        cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        drive_idle();
        rst = 1;
        ram_load = 1;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        md_locked = 0; md_starve = 0; md_pv = 0; md_pown = 0; md_pdata = 0;
        md_p0 = 0; md_p1 = 0; md_pw = 0; exp_g0 = 0; exp_g1 = 0;
        @(posedge clk);
        #1;
        ram_load = 0;
        test_reset();
        test_core_read();
        test_contention();
        test_lock_burst();
        test_reset_in_lock();
        test_random();
`ifdef RYSY_ARB_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
